// File: rtl/load_extend_unit_pkg.sv
// Shared load-size encodings and the alignment rule used by the load extend unit.
package load_extend_unit_pkg;

  typedef enum logic [1:0] {
    LSIZE_BYTE  = 2'd0,
    LSIZE_HALF  = 2'd1,
    LSIZE_WORD  = 2'd2,
    LSIZE_DWORD = 2'd3
  } lsize_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic off_fault(logic [2:0] off, logic [1:0] size);
    case (size)
      LSIZE_BYTE: return 1'b0;
      LSIZE_HALF: return off[0];
      LSIZE_WORD: return |off[1:0];
      default:    return |off;
    endcase
  endfunction

endpackage

// File: rtl/load_extend_unit_if.sv
// Request/response bundle between memory read return and writeback.
interface load_extend_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  localparam int OFF_WIDTH = $clog2(DATA_WIDTH/8);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [OFF_WIDTH-1:0]  in_offset;
  logic [1:0]            in_size;
  logic                  in_signed;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_misaligned;

  modport slave (
    input  in_valid, in_data, in_offset, in_size, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_misaligned
  );

  modport master (
    output in_valid, in_data, in_offset, in_size, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_misaligned
  );

endinterface

// File: rtl/load_extend_unit_extend_core.sv
// Combinational field extraction and sign/zero extension with misalignment detection.
module load_extend_unit_extend_core
  import load_extend_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int OFF_WIDTH = $clog2(DATA_WIDTH/8)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [OFF_WIDTH-1:0]  offset_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  misaligned_o
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic                  sign_bit;
  logic                  too_wide;
  logic                  mis;

  assign shifted = data_i >> {offset_i, 3'b000};

  // A full-width mask makes ~mask zero, so full-width loads ignore signed_i.
  always_comb begin
    mask     = '1;
    sign_bit = shifted[DATA_WIDTH-1];
    too_wide = 1'b0;
    case (size_i)
      LSIZE_BYTE: begin
        mask     = DATA_WIDTH'(8'hff);
        sign_bit = shifted[7];
      end
      LSIZE_HALF: begin
        mask     = DATA_WIDTH'(16'hffff);
        sign_bit = shifted[15];
      end
      LSIZE_WORD: begin
        mask     = DATA_WIDTH'(32'hffff_ffff);
        sign_bit = shifted[31];
      end
      default: too_wide = (DATA_WIDTH < 64);
    endcase
    mis = too_wide | off_fault(3'(offset_i), size_i);
    if (mis) result_o = '0;
    else     result_o = (shifted & mask) | ((signed_i & sign_bit) ? ~mask : '0);
    misaligned_o = mis;
  end

endmodule

// File: rtl/load_extend_unit.sv
// Load extend unit: extend_core followed by a two-entry main/skid output pipeline.
module load_extend_unit
  import load_extend_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input logic                clk,
  input logic                reset,
  input logic                flush,
  load_extend_unit_if.slave  bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  mis;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, drain;

  load_extend_unit_extend_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .data_i       (bus.in_data),
    .offset_i     (bus.in_offset),
    .size_i       (bus.in_size),
    .signed_i     (bus.in_signed),
    .result_o     (in_entry.data),
    .misaligned_o (in_entry.mis)
  );
  assign in_entry.tag = bus.in_tag;

  assign bus.in_ready       = ~skid_valid_q;
  assign bus.out_valid      = main_valid_q;
  assign bus.out_data       = main_q.data;
  assign bus.out_tag        = main_q.tag;
  assign bus.out_misaligned = main_q.mis;

  assign accept = bus.in_valid & ~skid_valid_q & ~flush;
  assign drain  = main_valid_q & bus.out_ready;

  // The skid is only ever filled while main is held, so an input can never
  // arrive in the same cycle the skid moves into main.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// Randomized and directed bench for 32- and 64-bit load_extend_unit instances against a queue model.
module tb_load_extend_unit;

  logic clk, reset, flush;
  int   checks = 0;
  int   failures = 0;
  int   pops32 = 0;

  load_extend_unit_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) if32();
  load_extend_unit_if #(.DATA_WIDTH(64), .TAG_WIDTH(5)) if64();

  load_extend_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if32)
  );
  load_extend_unit #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if64)
  );

  typedef struct {
    logic [4:0]  tag;
    logic [63:0] data;
    logic        mis;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: {misaligned, result} from the load rules with plain arithmetic.
  function automatic logic [64:0] ref_ext(input logic [63:0] d, input int off, input int sz,
                                          input bit sg, input int dw);
    int          nb;
    int          bits;
    logic [63:0] f, m;
    nb   = 1 << sz;
    bits = nb * 8;
    if ((off % nb) != 0 || bits > dw) return {1'b1, 64'd0};
    f = d >> (off * 8);
    m = (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    f = f & m;
    if (sg && bits < dw && ((f >> (bits - 1)) & 64'd1) == 64'd1) f = f | ~m;
    if (dw == 32) f = f & 64'h0000_0000_FFFF_FFFF;
    return {1'b0, f};
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [64:0] r;
    if (reset) q32.delete();
    else begin
      check("in_ready32", 64'(if32.in_ready), 64'(q32.size() < 2));
      check("out_valid32", 64'(if32.out_valid), 64'(q32.size() > 0));
      if (flush) q32.delete();
      else begin
        if (if32.out_valid && if32.out_ready && q32.size() != 0) begin
          e = q32.pop_front();
          pops32++;
          check("tag32", 64'(if32.out_tag), 64'(e.tag));
          check("data32", 64'(if32.out_data), e.data);
          check("mis32", 64'(if32.out_misaligned), 64'(e.mis));
        end
        if (if32.in_valid && if32.in_ready) begin
          r = ref_ext(64'(if32.in_data), int'(if32.in_offset), int'(if32.in_size), if32.in_signed, 32);
          e.tag = if32.in_tag; e.data = r[63:0]; e.mis = r[64];
          q32.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [64:0] r;
    if (reset) q64.delete();
    else begin
      check("in_ready64", 64'(if64.in_ready), 64'(q64.size() < 2));
      check("out_valid64", 64'(if64.out_valid), 64'(q64.size() > 0));
      if (flush) q64.delete();
      else begin
        if (if64.out_valid && if64.out_ready && q64.size() != 0) begin
          e = q64.pop_front();
          check("tag64", 64'(if64.out_tag), 64'(e.tag));
          check("data64", if64.out_data, e.data);
          check("mis64", 64'(if64.out_misaligned), 64'(e.mis));
        end
        if (if64.in_valid && if64.in_ready) begin
          r = ref_ext(if64.in_data, int'(if64.in_offset), int'(if64.in_size), if64.in_signed, 64);
          e.tag = if64.in_tag; e.data = r[63:0]; e.mis = r[64];
          q64.push_back(e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input bit s64, input logic [63:0] d, input int off, input int sz,
                        input bit sg, input logic [4:0] tag);
    if (s64) begin
      if64.in_valid = 1'b1; if64.in_data = d; if64.in_offset = 3'(off);
      if64.in_size = 2'(sz); if64.in_signed = sg; if64.in_tag = tag;
    end else begin
      if32.in_valid = 1'b1; if32.in_data = d[31:0]; if32.in_offset = 2'(off);
      if32.in_size = 2'(sz); if32.in_signed = sg; if32.in_tag = tag;
    end
  endtask

  task automatic push(input bit s64, input logic [63:0] d, input int off, input int sz,
                      input bit sg, input logic [4:0] tag);
    bit ok, r;
    ok = 1'b0;
    set_in(s64, d, off, sz, sg, tag);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      r = s64 ? if64.in_ready : if32.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (s64) if64.in_valid = 1'b0; else if32.in_valid = 1'b0;
    if (!ok) check("push_timeout", 64'(ok), 64'd1);
  endtask

  task automatic expect_ld(input bit s64, input logic [63:0] d, input int off, input int sz,
                           input bit sg, input logic [63:0] exp_d, input bit exp_mis);
    if (s64) if64.out_ready = 1'b1; else if32.out_ready = 1'b1;
    push(s64, d, off, sz, sg, 5'(off + 3 * sz));
    @(negedge clk);
    if (s64) begin
      check("ld64_valid", 64'(if64.out_valid), 64'd1);
      check("ld64_data", if64.out_data, exp_d);
      check("ld64_mis", 64'(if64.out_misaligned), 64'(exp_mis));
    end else begin
      check("ld32_valid", 64'(if32.out_valid), 64'd1);
      check("ld32_data", 64'(if32.out_data), exp_d);
      check("ld32_mis", 64'(if32.out_misaligned), 64'(exp_mis));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input bit s64);
    logic [63:0] d;
    d = {$urandom, $urandom};
    set_in(s64, d, s64 ? $urandom_range(0, 7) : $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 5'($urandom));
    if (s64) begin
      if64.in_valid  = 1'($urandom_range(0, 1));
      if64.out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      if32.in_valid  = 1'($urandom_range(0, 1));
      if32.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    flush = 1'b0;
    if32.in_valid = 0; if32.in_data = 0; if32.in_offset = 0; if32.in_size = 0;
    if32.in_signed = 0; if32.in_tag = 0; if32.out_ready = 1;
    if64.in_valid = 0; if64.in_data = 0; if64.in_offset = 0; if64.in_size = 0;
    if64.in_signed = 0; if64.in_tag = 0; if64.out_ready = 1;
    #2;
    check("rst_out_valid", 64'(if32.out_valid), 64'd0);
    check("rst_out_data", 64'(if32.out_data), 64'd0);
    check("rst_out_tag", 64'(if32.out_tag), 64'd0);
    check("rst_out_mis", 64'(if32.out_misaligned), 64'd0);
    check("rst_out_valid64", 64'(if64.out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    expect_ld(0, 64'h1234_8078, 1, 0, 1, 64'hFFFF_FF80, 0);
    expect_ld(0, 64'h1234_8078, 1, 0, 0, 64'h0000_0080, 0);
    expect_ld(0, 64'h8001_1234, 2, 1, 1, 64'hFFFF_8001, 0);
    expect_ld(0, 64'h8001_1234, 1, 1, 1, 64'h0, 1);
    expect_ld(0, 64'h8001_1234, 0, 3, 1, 64'h0, 1);
    expect_ld(0, 64'h8000_0000, 0, 2, 1, 64'h8000_0000, 0);
    expect_ld(1, 64'h8000_0000_0000_0000, 4, 2, 1, 64'hFFFF_FFFF_8000_0000, 0);
    expect_ld(1, 64'h8765_4321_0FED_CBA9, 0, 3, 1, 64'h8765_4321_0FED_CBA9, 0);
    expect_ld(1, 64'h8765_4321_0FED_CBA9, 4, 3, 0, 64'h0, 1);

    // Backpressure: third request must wait for the first output transfer.
    p0 = pops32;
    if32.out_ready = 1'b0;
    set_in(0, 64'h11, 0, 0, 0, 5'd1);
    @(negedge clk); check("bp_ready1", 64'(if32.in_ready), 64'd1);
    @(posedge clk); #1 set_in(0, 64'h22, 0, 0, 0, 5'd2);
    @(negedge clk); check("bp_ready2", 64'(if32.in_ready), 64'd1);
    @(posedge clk); #1 set_in(0, 64'h33, 0, 0, 0, 5'd3);
    @(negedge clk); check("bp_ready3", 64'(if32.in_ready), 64'd0);
    @(posedge clk); #1 if32.out_ready = 1'b1;
    push(0, 64'h33, 0, 0, 0, 5'd3);
    for (int n = 0; n < 20 && q32.size() != 0; n++) idle(1);
    idle(1);
    check("bp_count", 64'(pops32 - p0), 64'd3);

    // Flush with both entries full and a concurrent input.
    if32.out_ready = 1'b0;
    push(0, 64'h44, 0, 0, 0, 5'd4);
    push(0, 64'h55, 0, 0, 0, 5'd5);
    @(negedge clk); check("fl_full", 64'(if32.in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    set_in(0, 64'h99, 0, 0, 0, 5'd9);
    @(posedge clk); #1;
    flush = 1'b0;
    if32.in_valid = 1'b0;
    @(negedge clk);
    check("fl_out_valid", 64'(if32.out_valid), 64'd0);
    check("fl_in_ready", 64'(if32.in_ready), 64'd1);
    @(posedge clk); #1 if32.out_ready = 1'b1;
    idle(3);

    // Asynchronous reset while main holds a misaligned result.
    if32.out_ready = 1'b0;
    push(0, 64'h1234, 1, 1, 1, 5'd7);
    check("rst_pre_valid", 64'(if32.out_valid), 64'd1);
    check("rst_pre_mis", 64'(if32.out_misaligned), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_valid", 64'(if32.out_valid), 64'd0);
    check("rst_async_data", 64'(if32.out_data), 64'd0);
    check("rst_async_mis", 64'(if32.out_misaligned), 64'd0);
    check("rst_async_tag", 64'(if32.out_tag), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    expect_ld(0, 64'h0000_00A5, 0, 0, 0, 64'h0000_00A5, 0);

    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      drive_rand(0);
      drive_rand(1);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    if32.in_valid = 1'b0; if32.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.out_ready = 1'b1;
    idle(5);
    check("drain32", 64'(q32.size()), 64'd0);
    check("drain64", 64'(q64.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
